ex_hazard_ctrl: RTL and testbench
=================================

# ex_hazard_ctrl

Pipeline hazard and execute-stage sequencing controller for the 5-stage MIPS core. Generates the forwarding selects for the execute-stage operand muxes and the decode-stage branch comparator. Detects load-use and branch-compare hazards and drives stall/flush for the F/D/E/M pipeline registers. Also sequences multi-cycle execute operations (iterative mult/div) through an IDLE/RUN/DONE state machine that holds EX and injects bubbles into MEM.

## Interface
Parameters:
- op_width, 5, register-address width
- forward_sel_width, 2, width of forward_ae/forward_be
- mc_latency, 32, RUN-state cycles for a multi-cycle op (legal range 1..2^cnt_width)
- cnt_width, 6, width of the multi-cycle down-counter

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- rs_d, rt_d  in  op_width  source registers of the instruction in decode
- rs_e, rt_e  in  op_width  source registers of the instruction in execute
- write_reg_e, write_reg_m, write_reg_w  in  op_width  destination register per stage
- reg_write_e, reg_write_m, reg_write_w  in  1  register-write enable per stage
- mem_to_reg_e, mem_to_reg_m  in  1  instruction in that stage is a load
- branch_d  in  1  decode holds a branch
- mc_start_e  in  1  execute holds a multi-cycle op
- forward_ae, forward_be  out  forward_sel_width  00 = register file, 01 = result_w, 10 = alu_out_m; 11 never driven
- forward_ad, forward_bd  out  1  decode branch operand taken from alu_out_m
- stall_f, stall_d, stall_e  out  1  hold the PC / IF-ID / ID-EX register
- flush_e, flush_m  out  1  clear ID-EX / EX-MEM to a bubble
- mc_busy  out  1  state == RUN
- mc_done  out  1  state == DONE
- mc_count  out  cnt_width  current down-counter value

## Operation
- Register 0 never matches in any comparison below.
- **Forward A (execute):**
  - 10 if reg_write_m and write_reg_m == rs_e.
  - Else 01 if reg_write_w and write_reg_w == rs_e.
  - Else 00.
  - MEM has priority over WB.
- **Forward B (execute):** same rules, using rt_e.
- **Forward AD/BD (decode):** 1 if reg_write_m and write_reg_m == rs_d (rt_d for BD).
- **lw_stall:** mem_to_reg_e and write_reg_e ∈ {rs_d, rt_d}.
- **br_stall:** branch_d and at least one of:
  - reg_write_e and write_reg_e ∈ {rs_d, rt_d}
  - mem_to_reg_m and write_reg_m ∈ {rs_d, rt_d}
- **mc_hold:** (state == IDLE and mc_start_e) or state == RUN.
- **Stall/flush outputs:**
  - stall_f = stall_d = lw_stall | br_stall | mc_hold
  - stall_e = mc_hold
  - flush_m = mc_hold
  - flush_e = (lw_stall | br_stall) and !mc_hold. EX is frozen during mc_hold, so it is never flushed then.
- **FSM** (registered state, reset state IDLE):
  - IDLE: if mc_start_e, go to RUN and load count = mc_latency − 1.
  - RUN: decrement count each cycle; when count == 0, go to DONE.
  - DONE: go to IDLE unconditionally. mc_start_e is ignored in DONE; the op leaves EX this cycle.
- A multi-cycle op occupies EX for mc_latency + 2 cycles: the IDLE detect cycle, mc_latency RUN cycles, and the DONE cycle.
- Back-to-back multi-cycle ops: the next op is detected in the IDLE cycle after DONE.

## Timing
- Forwards, stalls and flushes are combinational from inputs and state, settling in the same cycle.
- mc_busy, mc_done and mc_count are decoded from registers.
- **Reset:**
  - While rst is high: forwards = 0, stall_f/d/e = 0, flush_e = flush_m = 1.
  - At the edge: state = IDLE, count = 0, mc_busy = mc_done = 0.
  - Reset during RUN abandons the op; the FSM is IDLE on the cycle after the edge.
- **Simultaneous events:**
  - lw_stall together with mc_hold: mc_hold governs (no flush_e). The load-use check re-evaluates after DONE.
  - A write to the same register in both MEM and WB forwards from MEM (10).
- The counter never wraps: it loads in IDLE only and stops at 0.

## Test plan
- **Forwarding priority:** rs_e = 5, write_reg_m = 5 with reg_write_m = 1, write_reg_w = 5 with reg_write_w = 1 -> forward_ae = 10. Same with reg_write_m = 0 -> 01. With rs_e = 0 -> 00.
- **Load-use:** mem_to_reg_e = 1, write_reg_e = 8, rt_d = 8 -> stall_f = stall_d = flush_e = 1, stall_e = 0 for one cycle. After EX advances (mem_to_reg_e = 0) -> all deasserted.
- **Branch hazard:** branch_d = 1, rs_d = 3, reg_write_e = 1, write_reg_e = 3 -> stall and flush_e. Next cycle write_reg_m = 3, reg_write_m = 1, mem_to_reg_m = 0 -> no stall, forward_ad = 1.
- **Multi-cycle op, mc_latency = 4:**
  - mc_start_e high from cycle 0 -> stall_e = 1 on cycles 0–4; mc_busy = 1 on cycles 1–4; mc_count = 3, 2, 1, 0.
  - mc_done = 1 on cycle 5 with stall_e = 0; IDLE on cycle 6.
- **Reset mid-RUN:** rst at count = 2 -> next cycle state IDLE, mc_busy = 0, mc_count = 0. While rst is high, flush_e = flush_m = 1.
- **Back-to-back multi-cycle ops:** mc_start_e held high through DONE -> second op detected in cycle 6, and total stall_e high cycles = 2 × (mc_latency + 1).

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core, plus the IDLE/RUN/DONE
// sequencer that holds EX and bubbles MEM while an iterative mult/div runs.
module ex_hazard_ctrl #(
    parameter int op_width          = 5,
    parameter int forward_sel_width = 2,
    parameter int mc_latency        = 32,
    parameter int cnt_width         = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [op_width-1:0]          rs_d,
    input  logic [op_width-1:0]          rt_d,
    input  logic [op_width-1:0]          rs_e,
    input  logic [op_width-1:0]          rt_e,
    input  logic [op_width-1:0]          write_reg_e,
    input  logic [op_width-1:0]          write_reg_m,
    input  logic [op_width-1:0]          write_reg_w,
    input  logic                         reg_write_e,
    input  logic                         reg_write_m,
    input  logic                         reg_write_w,
    input  logic                         mem_to_reg_e,
    input  logic                         mem_to_reg_m,
    input  logic                         branch_d,
    input  logic                         mc_start_e,
    output logic [forward_sel_width-1:0] forward_ae,
    output logic [forward_sel_width-1:0] forward_be,
    output logic                         forward_ad,
    output logic                         forward_bd,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         stall_e,
    output logic                         flush_e,
    output logic                         flush_m,
    output logic                         mc_busy,
    output logic                         mc_done,
    output logic [cnt_width-1:0]         mc_count,
    output logic [1:0]                   mc_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam logic [forward_sel_width-1:0] FWD_RF  = forward_sel_width'(0);
    localparam logic [forward_sel_width-1:0] FWD_WB  = forward_sel_width'(1);
    localparam logic [forward_sel_width-1:0] FWD_MEM = forward_sel_width'(2);
    localparam logic [cnt_width-1:0]         CNT_LOAD = cnt_width'(mc_latency - 1);

    mc_state_t            state, state_next;
    logic [cnt_width-1:0] count, count_next;
    logic                 lw_stall, br_stall, mc_hold;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic hit(input logic [op_width-1:0] a, input logic [op_width-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (mc_start_e) begin
                    state_next = RUN;
                    count_next = CNT_LOAD;
                end
            end
            RUN: begin
                if (count == '0) state_next = DONE;
                else             count_next = count - 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mc_hold  = ((state == IDLE) && mc_start_e) || (state == RUN);
        lw_stall = mem_to_reg_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
        br_stall = branch_d &&
                   ((reg_write_e  && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
                    (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));

        forward_ae = FWD_RF;
        forward_be = FWD_RF;
        forward_ad = 1'b0;
        forward_bd = 1'b0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_e    = 1'b1;
        flush_m    = 1'b1;

        // Reset keeps everything quiet except the flushes, which bubble EX/MEM.
        if (!rst) begin
            if (reg_write_m && hit(write_reg_m, rs_e))      forward_ae = FWD_MEM;
            else if (reg_write_w && hit(write_reg_w, rs_e)) forward_ae = FWD_WB;
            if (reg_write_m && hit(write_reg_m, rt_e))      forward_be = FWD_MEM;
            else if (reg_write_w && hit(write_reg_w, rt_e)) forward_be = FWD_WB;
            forward_ad = reg_write_m && hit(write_reg_m, rs_d);
            forward_bd = reg_write_m && hit(write_reg_m, rt_d);
            stall_f    = lw_stall || br_stall || mc_hold;
            stall_d    = lw_stall || br_stall || mc_hold;
            stall_e    = mc_hold;
            flush_m    = mc_hold;
            // EX is frozen during mc_hold, so a pending hazard waits rather than flushing it.
            flush_e    = (lw_stall || br_stall) && !mc_hold;
        end
    end

    assign mc_busy  = (state == RUN);
    assign mc_done  = (state == DONE);
    assign mc_count = count;
    assign mc_state = state;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with mc_latency = 4; expected values are
// hand-derived from the forwarding/stall rules and the IDLE/RUN/DONE timing.
module tb_ex_hazard_ctrl;

    localparam int OPW = 5;
    localparam int FSW = 2;
    localparam int LAT = 4;
    localparam int CW  = 6;

    logic           clk;
    logic           rst;
    logic [OPW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [OPW-1:0] write_reg_e, write_reg_m, write_reg_w;
    logic           reg_write_e, reg_write_m, reg_write_w;
    logic           mem_to_reg_e, mem_to_reg_m, branch_d, mc_start_e;
    logic [FSW-1:0] forward_ae, forward_be;
    logic           forward_ad, forward_bd;
    logic           stall_f, stall_d, stall_e, flush_e, flush_m;
    logic           mc_busy, mc_done;
    logic [CW-1:0]  mc_count;
    logic [1:0]     mc_state;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];

    ex_hazard_ctrl #(
        .op_width(OPW), .forward_sel_width(FSW), .mc_latency(LAT), .cnt_width(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .branch_d(branch_d), .mc_start_e(mc_start_e),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_e(flush_e), .flush_m(flush_m),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_count(mc_count), .mc_state(mc_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
        reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0; branch_d = 1'b0; mc_start_e = 1'b0;
    endtask

    // Inputs change 1 time unit after the edge; checks happen 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_hazard(input string tag, input logic sf, input logic sd,
                                input logic se, input logic fe, input logic fm);
        check({tag, ".stall_f"}, 32'(stall_f), 32'(sf));
        check({tag, ".stall_d"}, 32'(stall_d), 32'(sd));
        check({tag, ".stall_e"}, 32'(stall_e), 32'(se));
        check({tag, ".flush_e"}, 32'(flush_e), 32'(fe));
        check({tag, ".flush_m"}, 32'(flush_m), 32'(fm));
    endtask

    initial begin
        int stall_cnt;
        logic [CW-1:0] exp_cnt;
        logic exp_se[7]   = '{1, 1, 1, 1, 1, 0, 0};
        logic exp_busy[7] = '{0, 1, 1, 1, 1, 0, 0};
        logic exp_done[7] = '{0, 0, 0, 0, 0, 1, 0};

        // reset: forwards and stalls quiet, flushes high, even with hazards present
        clear_inputs();
        rst = 1'b1;
        rs_e = 5'd5; write_reg_m = 5'd5; reg_write_m = 1'b1;
        mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8; mc_start_e = 1'b1;
        settle();
        check("rst.forward_ae", 32'(forward_ae), 32'd0);
        check_hazard("rst", 0, 0, 0, 1, 1);
        step();
        settle();
        check("rst.mc_busy", 32'(mc_busy), 32'd0);
        check("rst.mc_done", 32'(mc_done), 32'd0);
        check("rst.mc_count", 32'(mc_count), 32'd0);
        check("rst.mc_state", 32'(mc_state), 32'd0);
        clear_inputs();
        rst = 1'b0;
        step();

        // forwarding priority
        rs_e = 5'd5; write_reg_m = 5'd5; reg_write_m = 1'b1; write_reg_w = 5'd5; reg_write_w = 1'b1;
        rt_e = 5'd7;
        settle();
        check("fwd.mem_over_wb", 32'(forward_ae), 32'd2);
        check("fwd.b_none", 32'(forward_be), 32'd0);
        reg_write_m = 1'b0;
        settle();
        check("fwd.wb", 32'(forward_ae), 32'd1);
        rs_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0; reg_write_m = 1'b1;
        settle();
        check("fwd.reg0", 32'(forward_ae), 32'd0);
        rt_e = 5'd9; write_reg_w = 5'd9; write_reg_m = 5'd4;
        settle();
        check("fwd.b_wb", 32'(forward_be), 32'd1);
        write_reg_m = 5'd9;
        settle();
        check("fwd.b_mem", 32'(forward_be), 32'd2);
        check_hazard("fwd", 0, 0, 0, 0, 0);
        clear_inputs();

        // load-use
        mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
        settle();
        check_hazard("lw", 1, 1, 0, 1, 0);
        step();
        mem_to_reg_e = 1'b0;
        settle();
        check_hazard("lw_clear", 0, 0, 0, 0, 0);
        clear_inputs();

        // branch compare hazard, then resolved by MEM forwarding
        branch_d = 1'b1; rs_d = 5'd3; reg_write_e = 1'b1; write_reg_e = 5'd3;
        settle();
        check_hazard("br_e", 1, 1, 0, 1, 0);
        step();
        reg_write_e = 1'b0; write_reg_e = 5'd0;
        write_reg_m = 5'd3; reg_write_m = 1'b1; mem_to_reg_m = 1'b0;
        settle();
        check_hazard("br_m", 0, 0, 0, 0, 0);
        check("br.forward_ad", 32'(forward_ad), 32'd1);
        check("br.forward_bd", 32'(forward_bd), 32'd0);
        mem_to_reg_m = 1'b1;
        settle();
        check_hazard("br_load_m", 1, 1, 0, 1, 0);
        clear_inputs();
        step();

        // multi-cycle op; a load-use hazard overlaps cycle 2 and must not flush EX
        exp_q = '{3, 2, 1, 0};
        mc_start_e = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) mc_start_e = 1'b0;
            if (c == 2) begin
                mem_to_reg_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
            end else begin
                mem_to_reg_e = 1'b0; write_reg_e = 5'd0; rt_d = 5'd0;
            end
            settle();
            check($sformatf("mc%0d.stall_e", c), 32'(stall_e), 32'(exp_se[c]));
            check($sformatf("mc%0d.flush_m", c), 32'(flush_m), 32'(exp_se[c]));
            check($sformatf("mc%0d.flush_e", c), 32'(flush_e), 32'd0);
            check($sformatf("mc%0d.stall_f", c), 32'(stall_f), 32'(exp_se[c]));
            check($sformatf("mc%0d.mc_busy", c), 32'(mc_busy), 32'(exp_busy[c]));
            check($sformatf("mc%0d.mc_done", c), 32'(mc_done), 32'(exp_done[c]));
            if (c >= 1 && c <= 4) begin
                if (exp_q.size() > 0) exp_cnt = exp_q.pop_front();
                else                  exp_cnt = '1;
            end else begin
                exp_cnt = '0;
            end
            check($sformatf("mc%0d.mc_count", c), 32'(mc_count), 32'(exp_cnt));
            step();
        end
        check("mc.idle_after", 32'(mc_state), 32'd0);
        check("mc.queue_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-RUN at count == 2
        mc_start_e = 1'b1;
        step();
        step();
        settle();
        check("rstrun.count_before", 32'(mc_count), 32'd2);
        rst = 1'b1;
        settle();
        check_hazard("rstrun", 0, 0, 0, 1, 1);
        step();
        rst = 1'b0;
        mc_start_e = 1'b0;
        settle();
        check("rstrun.mc_busy", 32'(mc_busy), 32'd0);
        check("rstrun.mc_count", 32'(mc_count), 32'd0);
        check("rstrun.mc_state", 32'(mc_state), 32'd0);
        check("rstrun.stall_e", 32'(stall_e), 32'd0);
        step();

        // back-to-back ops: start held through DONE
        stall_cnt = 0;
        mc_start_e = 1'b1;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (stall_e) stall_cnt++;
            if (c == 5) begin
                check("b2b.done5", 32'(mc_done), 32'd1);
                check("b2b.stall5", 32'(stall_e), 32'd0);
            end
            if (c == 6) begin
                check("b2b.redetect6", 32'(stall_e), 32'd1);
                check("b2b.idle6", 32'(mc_state), 32'd0);
            end
            step();
        end
        mc_start_e = 1'b0;
        check("b2b.stall_total", 32'(stall_cnt), 32'(2 * (LAT + 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
